// File: rtl/pip_flush_ctrl.sv
// Pipeline flush/redirect controller: arbitrates flush sources by age, stretches the flush pulse
// and hands the new PC to the frontend over ready/valid. Optional counter: PIP_FLUSH_PERF_EN.
module pip_flush_ctrl #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NSRC         = 3,
  parameter int unsigned NSTAGE       = 6,
  parameter int unsigned SW           = $clog2(NSTAGE),
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [NSRC-1:0]      req_valid_i,
  input  logic [NSRC*XLEN-1:0] req_pc_i,
  input  logic [NSRC*SW-1:0]   req_stage_i,
  input  logic [NSRC-1:0]      req_flushbpu_i,
  output logic [NSRC-1:0]      req_grant_o,
  input  logic                 hold_req_i,
  output logic [NSTAGE-1:0]    flush_o,
  output logic                 hold_o,
  output logic                 flushbpu_o,
  output logic [XLEN-1:0]      newpc_o,
  output logic                 newpc_valid_o,
  input  logic                 newpc_ready_i,
`ifdef PIP_FLUSH_PERF_EN
  output logic [31:0]          flush_cnt_o,
`endif
  output logic                 busy_o
);

  typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

  localparam logic [SW-1:0] MaxStage = SW'(NSTAGE - 1);
  localparam logic [3:0]    CntInit  = 4'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic            fbpu_q, fbpu_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            win_found;
  logic [NSRC-1:0] win_oh;
  logic [SW-1:0]   win_stage;
  logic [XLEN-1:0] win_pc;
  logic            win_fbpu;
  logic [SW-1:0]   cand_stage;
  logic            accept;

  // Oldest stage wins; strict compare keeps ties with the lowest source index.
  always_comb begin
    win_found  = 1'b0;
    win_oh     = '0;
    win_stage  = '0;
    win_pc     = '0;
    win_fbpu   = 1'b0;
    cand_stage = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      cand_stage = req_stage_i[i*SW +: SW];
      if (cand_stage > MaxStage) cand_stage = MaxStage;
      if (req_valid_i[i] && (!win_found || cand_stage > win_stage)) begin
        win_found = 1'b1;
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_stage = cand_stage;
        win_pc    = req_pc_i[i*XLEN +: XLEN];
        win_fbpu  = req_flushbpu_i[i];
      end
    end
  end

  // Younger-or-equal requests during an active flush are already covered and get dropped.
  always_comb begin
    accept = 1'b0;
    unique case (state_q)
      StIdle:              accept = win_found;
      StFlush, StRedirect: accept = win_found && (win_stage > stage_q);
      default:             accept = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stage_d = stage_q;
    fbpu_d  = fbpu_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = StFlush;
      pc_d    = win_pc;
      stage_d = win_stage;
      fbpu_d  = win_fbpu;
      cnt_d   = CntInit;
    end else begin
      unique case (state_q)
        StFlush: begin
          if (cnt_q == 4'd0) state_d = StRedirect;
          else               cnt_d   = cnt_q - 4'd1;
        end
        StRedirect: begin
          if (newpc_ready_i) state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      stage_q <= '0;
      fbpu_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stage_q <= stage_d;
      fbpu_q  <= fbpu_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    flush_o = '0;
    for (int i = 0; i < int'(NSTAGE); i++) begin
      flush_o[i] = (state_q == StFlush) && (SW'(i) <= stage_q);
    end
  end

  assign req_grant_o   = accept ? win_oh : '0;
  assign flushbpu_o    = (state_q == StFlush) && fbpu_q;
  assign newpc_valid_o = (state_q == StRedirect);
  assign newpc_o       = (state_q == StRedirect) ? pc_q : '0;
  assign busy_o        = (state_q != StIdle);
  assign hold_o        = hold_req_i || (state_q != StIdle);

`ifdef PIP_FLUSH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      perf_q <= '0;
    end else if (accept && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign flush_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_pip_flush_ctrl.sv
// Directed bench for pip_flush_ctrl: one instance with a 1-cycle flush, one with a 3-cycle flush.
module tb_pip_flush_ctrl;

  logic         clk = 1'b0;
  logic         srst;
  logic [2:0]   req_valid;
  logic [191:0] req_pc;
  logic [8:0]   req_stage;
  logic [2:0]   req_flushbpu;
  logic         hold_req;
  logic         newpc_ready;

  logic [2:0]  grant1, grant3;
  logic [5:0]  flush1, flush3;
  logic        hold1, hold3, fbpu1, fbpu3, valid1, valid3, busy1, busy3;
  logic [63:0] newpc1, newpc3;
`ifdef PIP_FLUSH_PERF_EN
  logic [31:0] cnt1, cnt3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pip_flush_ctrl #(.FLUSH_CYCLES(1)) u_dut (
    .clk_i(clk), .srst_i(srst), .req_valid_i(req_valid), .req_pc_i(req_pc),
    .req_stage_i(req_stage), .req_flushbpu_i(req_flushbpu), .req_grant_o(grant1),
    .hold_req_i(hold_req), .flush_o(flush1), .hold_o(hold1), .flushbpu_o(fbpu1),
    .newpc_o(newpc1), .newpc_valid_o(valid1), .newpc_ready_i(newpc_ready),
`ifdef PIP_FLUSH_PERF_EN
    .flush_cnt_o(cnt1),
`endif
    .busy_o(busy1)
  );

  pip_flush_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
    .clk_i(clk), .srst_i(srst), .req_valid_i(req_valid), .req_pc_i(req_pc),
    .req_stage_i(req_stage), .req_flushbpu_i(req_flushbpu), .req_grant_o(grant3),
    .hold_req_i(hold_req), .flush_o(flush3), .hold_o(hold3), .flushbpu_o(fbpu3),
    .newpc_o(newpc3), .newpc_valid_o(valid3), .newpc_ready_i(newpc_ready),
`ifdef PIP_FLUSH_PERF_EN
    .flush_cnt_o(cnt3),
`endif
    .busy_o(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int src, input logic [63:0] pc, input logic [2:0] stg,
                         input logic fb);
    req_valid[src]          = 1'b1;
    req_pc[src*64 +: 64]    = pc;
    req_stage[src*3 +: 3]   = stg;
    req_flushbpu[src]       = fb;
  endtask

  task automatic clr_req();
    req_valid    = '0;
    req_pc       = '0;
    req_stage    = '0;
    req_flushbpu = '0;
  endtask

  initial begin
    srst = 1'b1; hold_req = 1'b0; newpc_ready = 1'b0;
    clr_req();
    step(); step();
    srst = 1'b0;
    settle();

    // Reset state
    chk("rst_flush", 64'(flush1), 64'h0);
    chk("rst_valid", 64'(valid1), 64'h0);
    chk("rst_newpc", newpc1, 64'h0);
    chk("rst_busy", 64'(busy1), 64'h0);
    chk("rst_hold", 64'(hold1), 64'h0);

    // Single request, cycle 0
    set_req(1, 64'h8000_0040, 3'd2, 1'b1);
    settle();
    chk("single_grant", 64'(grant1), 64'b010);
    chk("single_c0_flush", 64'(flush1), 64'h0);
    step(); clr_req(); settle();
    chk("single_c1_flush", 64'(flush1), 64'b000111);
    chk("single_c1_fbpu", 64'(fbpu1), 64'h1);
    chk("single_c1_hold", 64'(hold1), 64'h1);
    chk("single_c1_valid", 64'(valid1), 64'h0);
    step(); settle();
    chk("single_c2_valid", 64'(valid1), 64'h1);
    chk("single_c2_newpc", newpc1, 64'h8000_0040);
    chk("single_c2_flush", 64'(flush1), 64'h0);
    chk("single_c2_fbpu", 64'(fbpu1), 64'h0);
    newpc_ready = 1'b1;
    step(); newpc_ready = 1'b0; settle();
    chk("single_c3_busy", 64'(busy1), 64'h0);
    chk("single_c3_valid", 64'(valid1), 64'h0);
    chk("single_c3_hold", 64'(hold1), 64'h0);

    // Simultaneous: oldest stage wins
    set_req(0, 64'h1000, 3'd3, 1'b0);
    set_req(2, 64'h2000, 3'd5, 1'b0);
    settle();
    chk("simul_grant", 64'(grant1), 64'b100);
    step(); clr_req(); settle();
    chk("simul_flush", 64'(flush1), 64'b111111);
    chk("simul_fbpu", 64'(fbpu1), 64'h0);
    step(); settle();
    chk("simul_newpc", newpc1, 64'h2000);
    newpc_ready = 1'b1;
    step(); newpc_ready = 1'b0;

    // Equal stages: lowest index wins
    set_req(0, 64'h3000, 3'd2, 1'b0);
    set_req(1, 64'h4000, 3'd2, 1'b0);
    settle();
    chk("tie_grant", 64'(grant1), 64'b001);
    step(); clr_req(); step(); settle();
    chk("tie_newpc", newpc1, 64'h3000);
    newpc_ready = 1'b1;
    step(); newpc_ready = 1'b0;

    // Preemption from REDIRECT
    set_req(1, 64'h5000, 3'd2, 1'b0);
    step(); clr_req(); step(); settle();
    chk("pre_in_redirect", 64'(valid1), 64'h1);
    set_req(0, 64'h6000, 3'd4, 1'b1);
    newpc_ready = 1'b1;
    settle();
    chk("pre_grant", 64'(grant1), 64'b001);
    step(); clr_req(); newpc_ready = 1'b0; settle();
    chk("pre_flush", 64'(flush1), 64'b011111);
    chk("pre_fbpu", 64'(fbpu1), 64'h1);
    chk("pre_valid_low", 64'(valid1), 64'h0);
    step(); settle();
    chk("pre_newpc", newpc1, 64'h6000);
    set_req(2, 64'h7000, 3'd1, 1'b0);
    settle();
    chk("drop_grant", 64'(grant1), 64'b000);
    step(); settle();
    chk("drop_newpc", newpc1, 64'h6000);
    chk("drop_flush", 64'(flush1), 64'h0);
    // Request in the completing cycle: not granted now, accepted next cycle in IDLE
    clr_req();
    set_req(1, 64'h7100, 3'd1, 1'b0);
    newpc_ready = 1'b1;
    settle();
    chk("done_grant", 64'(grant1), 64'b000);
    step(); newpc_ready = 1'b0; settle();
    chk("idle_busy", 64'(busy1), 64'h0);
    chk("idle_grant", 64'(grant1), 64'b010);
    step(); clr_req(); settle();
    chk("idle_flush", 64'(flush1), 64'b000011);

    // Stretch and backpressure on the 3-cycle instance
    srst = 1'b1;
    step(); srst = 1'b0;
    set_req(0, 64'hA5A5_0000_1234, 3'd1, 1'b1);
    settle();
    chk("str_grant", 64'(grant3), 64'b001);
    for (int c = 0; c < 3; c++) begin
      step(); clr_req(); settle();
      chk("str_flush", 64'(flush3), 64'b000011);
      chk("str_valid_low", 64'(valid3), 64'h0);
    end
    for (int c = 0; c < 5; c++) begin
      step(); settle();
      chk("bp_flush", 64'(flush3), 64'h0);
      chk("bp_valid", 64'(valid3), 64'h1);
      chk("bp_newpc", newpc3, 64'hA5A5_0000_1234);
      chk("bp_hold", 64'(hold3), 64'h1);
    end
    newpc_ready = 1'b1;
    step(); newpc_ready = 1'b0; settle();
    chk("bp_done_busy", 64'(busy3), 64'h0);

    // Reset during REDIRECT
    set_req(2, 64'hBEEF, 3'd3, 1'b1);
    step(); clr_req(); step(); settle();
    chk("mid_in_redirect", 64'(valid1), 64'h1);
    srst = 1'b1;
    step(); srst = 1'b0; settle();
    chk("mid_flush", 64'(flush1), 64'h0);
    chk("mid_fbpu", 64'(fbpu1), 64'h0);
    chk("mid_valid", 64'(valid1), 64'h0);
    chk("mid_newpc", newpc1, 64'h0);
    chk("mid_busy", 64'(busy1), 64'h0);
    chk("mid_hold0", 64'(hold1), 64'h0);
    hold_req = 1'b1;
    settle();
    chk("mid_hold1", 64'(hold1), 64'h1);
    hold_req = 1'b0;

    // Two accepts plus one preemption
    set_req(0, 64'h100, 3'd1, 1'b0);
    step(); clr_req();
    set_req(1, 64'h200, 3'd3, 1'b0);
    settle();
    chk("perf_preempt_grant", 64'(grant1), 64'b010);
    step(); clr_req(); step();
    newpc_ready = 1'b1;
    step(); newpc_ready = 1'b0;
    set_req(2, 64'h300, 3'd0, 1'b0);
    step(); clr_req(); settle();
    chk("perf_flush", 64'(flush1), 64'b000001);
`ifdef PIP_FLUSH_PERF_EN
    chk("perf_cnt", 64'(cnt1), 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
